// File: rtl/bounce_decoder.sv
// rtl/bounce_decoder.sv - tracks a one-hot bouncing pattern: position, direction, period count, fault flag
// Define BOUNCE_DECODER_ERRCNT_EN to build the saturating err_cnt violation counter.
module bounce_decoder #(
  parameter int N  = 8,
  parameter int PW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N-1:0]         Q_in,
  output logic [$clog2(N)-1:0] pos,
  output logic                 dir,
  output logic                 valid,
  output logic                 TC,
  output logic [PW-1:0]        periods,
  output logic                 err,
  output logic [7:0]           err_cnt
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] POS_MAX = IW'(N - 1);

  typedef enum logic [1:0] {SYNC, LOCK, TRACK, FAULT} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, pos_nx, exp_idx;
  logic          legal, dir_nx, exp_dir, tc_nx, viol;
  int            ones;

  always_comb begin
    idx  = '0;
    ones = 0;
    for (int i = 0; i < N; i++) begin
      if (Q_in[i]) begin
        idx  = IW'(i);
        ones = ones + 1;
      end
    end
    legal = (ones == 1);
  end

  // Next index the bounce must produce; the ends reflect and flip direction.
  always_comb begin
    exp_idx = '0;
    exp_dir = dir;
    if (dir) begin
      if (pos == '0) begin
        exp_idx = IW'(1);
        exp_dir = 1'b0;
      end else begin
        exp_idx = pos - IW'(1);
      end
    end else begin
      if (pos == POS_MAX) begin
        exp_idx = IW'(N - 2);
        exp_dir = 1'b1;
      end else begin
        exp_idx = pos + IW'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    dir_nx   = dir;
    tc_nx    = 1'b0;
    viol     = 1'b0;
    case (state)
      SYNC: begin
        if (legal) begin
          pos_nx   = idx;
          state_nx = LOCK;
        end
      end
      LOCK: begin
        if (!legal) begin
          state_nx = SYNC;
        end else if (pos != '0 && idx == pos - IW'(1)) begin
          pos_nx   = idx;
          dir_nx   = 1'b1;
          tc_nx    = (idx == '0);
          state_nx = TRACK;
        end else if (pos != POS_MAX && idx == pos + IW'(1)) begin
          pos_nx   = idx;
          dir_nx   = 1'b0;
          state_nx = TRACK;
        end else begin
          pos_nx = idx;
        end
      end
      TRACK: begin
        if (legal && idx == exp_idx) begin
          pos_nx = idx;
          dir_nx = exp_dir;
          tc_nx  = exp_dir && (idx == '0);
        end else begin
          viol     = 1'b1;
          state_nx = FAULT;
        end
      end
      FAULT: begin
        if (legal) begin
          pos_nx   = idx;
          state_nx = LOCK;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SYNC;
      pos     <= '0;
      dir     <= 1'b1;
      valid   <= 1'b0;
      TC      <= 1'b0;
      periods <= '0;
      err     <= 1'b0;
    end else begin
      TC <= 1'b0;
      if (ena) begin
        state <= state_nx;
        pos   <= pos_nx;
        dir   <= dir_nx;
        valid <= (state_nx == TRACK);
        TC    <= tc_nx;
        if (tc_nx) periods <= periods + PW'(1);
        if (viol) err <= 1'b1;
      end
    end
  end

`ifdef BOUNCE_DECODER_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (ena && viol && err_cnt != 8'hff) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_bounce_decoder.sv
// tb/tb_bounce_decoder.sv - scoreboard bench for bounce_decoder (N=8, PW=16 and PW=4 instances)
module tb_bounce_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ena;
  logic [7:0] q_in;

  logic [2:0]  pos, pos4;
  logic        dir, valid, tc, err, dir4, valid4, tc4, err4;
  logic [15:0] periods;
  logic [3:0]  periods4;
  logic [7:0]  err_cnt, err_cnt4;

  bounce_decoder #(.N(8), .PW(16)) dut (
    .clk(clk), .rst(rst), .ena(ena), .Q_in(q_in), .pos(pos), .dir(dir), .valid(valid),
    .TC(tc), .periods(periods), .err(err), .err_cnt(err_cnt)
  );

  bounce_decoder #(.N(8), .PW(4)) dut4 (
    .clk(clk), .rst(rst), .ena(ena), .Q_in(q_in), .pos(pos4), .dir(dir4), .valid(valid4),
    .TC(tc4), .periods(periods4), .err(err4), .err_cnt(err_cnt4)
  );

`ifdef BOUNCE_DECODER_ERRCNT_EN
  localparam int EC_MAX = 255;
`else
  localparam int EC_MAX = 0;
`endif

  typedef struct packed {
    logic [2:0]  pos;
    logic        dir;
    logic        valid;
    logic        tc;
    logic        err;
    logic [15:0] per;
    logic [7:0]  ec;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [2:0]  e_pos;
  logic        e_dir, e_valid, e_tc, e_err;
  logic [15:0] e_per;
  int          e_viol;

  function automatic logic [7:0] ec_exp(input int v);
    return (v > EC_MAX) ? 8'(EC_MAX) : 8'(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pos", 16'(pos), 16'(e.pos));
      chk("dir", 16'(dir), 16'(e.dir));
      chk("valid", 16'(valid), 16'(e.valid));
      chk("TC", 16'(tc), 16'(e.tc));
      chk("periods", periods, e.per);
      chk("err", 16'(err), 16'(e.err));
      chk("err_cnt", 16'(err_cnt), 16'(e.ec));
      chk("pw4_pos", 16'(pos4), 16'(e.pos));
      chk("pw4_dir", 16'(dir4), 16'(e.dir));
      chk("pw4_valid", 16'(valid4), 16'(e.valid));
      chk("pw4_TC", 16'(tc4), 16'(e.tc));
      chk("pw4_periods", 16'(periods4), 16'(e.per[3:0]));
      chk("pw4_err", 16'(err4), 16'(e.err));
      chk("pw4_err_cnt", 16'(err_cnt4), 16'(e.ec));
    end
  end

  // One clock: drive, let the edge sample it, then post the expected outputs.
  task automatic cyc(input logic r, input logic en, input logic [7:0] q);
    @(negedge clk);
    rst  = r;
    ena  = en;
    q_in = q;
    @(posedge clk);
    #1;
    sb.push_back('{e_pos, e_dir, e_valid, e_tc, e_err, e_per, ec_exp(e_viol)});
    e_tc = 1'b0;
  endtask

  task automatic sweep_in();
    for (int i = 7; i >= 0; i--) begin
      e_pos   = 3'(i);
      e_dir   = 1'b1;
      e_valid = (i != 7);
      e_tc    = (i == 0);
      if (i == 0) e_per++;
      cyc(1'b0, 1'b1, 8'(1 << i));
    end
  endtask

  task automatic up(input int hi);
    for (int i = int'(e_pos) + 1; i <= hi; i++) begin
      e_pos   = 3'(i);
      e_dir   = 1'b0;
      e_valid = 1'b1;
      cyc(1'b0, 1'b1, 8'(1 << i));
    end
  endtask

  task automatic down(input int lo);
    for (int i = int'(e_pos) - 1; i >= lo; i--) begin
      e_pos   = 3'(i);
      e_dir   = 1'b1;
      e_valid = 1'b1;
      e_tc    = (i == 0);
      if (i == 0) e_per++;
      cyc(1'b0, 1'b1, 8'(1 << i));
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; q_in = 8'h00;
    e_pos = 3'd0; e_dir = 1'b1; e_valid = 1'b0; e_tc = 1'b0;
    e_err = 1'b0; e_per = 16'd0; e_viol = 0;

    cyc(1'b1, 1'b0, 8'h00);

    // first descent: lock on 0x80, track from 0x40, TC on 0x01
    sweep_in();
    // full bounce back up and down
    up(7);
    down(0);

    // ena low: everything holds, TC drops
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 8'($urandom));

    // two-hot sample at pos=3, dir=1
    up(7);
    down(3);
    e_valid = 1'b0; e_err = 1'b1; e_viol++;
    cyc(1'b0, 1'b1, 8'h18);
    e_pos = 3'd2;
    cyc(1'b0, 1'b1, 8'h04);

    // non-adjacent LOCK samples, then enter TRACK at pos 0 moving right
    e_pos = 3'd7;
    cyc(1'b0, 1'b1, 8'h80);
    e_pos = 3'd1;
    cyc(1'b0, 1'b1, 8'h02);
    e_pos = 3'd0; e_dir = 1'b1; e_valid = 1'b1; e_tc = 1'b1; e_per++;
    cyc(1'b0, 1'b1, 8'h01);

    // wrong index at pos=4, dir=1, then 300 more violations to saturate
    up(7);
    down(4);
    e_valid = 1'b0; e_viol++;
    cyc(1'b0, 1'b1, 8'h40);
    for (int k = 0; k < 300; k++) begin
      e_pos = 3'd4; e_valid = 1'b0;
      cyc(1'b0, 1'b1, 8'h10);
      e_pos = 3'd3; e_dir = 1'b1; e_valid = 1'b1;
      cyc(1'b0, 1'b1, 8'h08);
      e_valid = 1'b0; e_viol++;
      cyc(1'b0, 1'b1, 8'h00);
    end

    // illegal in FAULT holds; illegal in LOCK drops to SYNC; SYNC relocks
    cyc(1'b0, 1'b1, 8'h00);
    e_pos = 3'd4;
    cyc(1'b0, 1'b1, 8'h10);
    cyc(1'b0, 1'b1, 8'h03);
    cyc(1'b0, 1'b1, 8'h00);
    e_pos = 3'd5;
    cyc(1'b0, 1'b1, 8'h20);
    e_pos = 3'd4; e_dir = 1'b1; e_valid = 1'b1;
    cyc(1'b0, 1'b1, 8'h10);

    // reset wins over a simultaneous sample
    e_pos = 3'd0; e_dir = 1'b1; e_valid = 1'b0; e_err = 1'b0; e_per = 16'd0; e_viol = 0;
    cyc(1'b1, 1'b1, 8'h08);

    // 16 TC pulses: PW=4 instance wraps back to 0
    sweep_in();
    for (int b = 0; b < 15; b++) begin
      up(7);
      down(0);
    end
    cyc(1'b0, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
